// File: rtl/mdu_iter.sv
// -----------------------------------------------------------------------------
// mdu_iter -- iterative multiply/divide unit sitting beside the execute ALU.
//
// Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from execute over a valid/ready
// handshake and owns the architectural HI/LO registers. Multiply is a
// radix-2 shift-add, divide is radix-2 restoring; both run on operand
// magnitudes and apply the sign correction in a final FIX cycle. A flush
// cancels whatever is in flight without touching HI/LO.
//
// Optional build macro: MDU_FAST_MULT_EN
//   defined   : MULT/MULTU use a single-cycle array product (IDLE->FIX),
//               result one cycle after accept.
//   undefined : multiply takes the 32-cycle shift-add path (33-cycle latency).
//
// Ports:
//   clk       in   clock, all state on rising edge
//   reset     in   asynchronous active-high reset
//   op_valid  in   request present
//   op_ready  out  unit can accept (IDLE)
//   mdu_op    in   [2:0] 000 MULT, 001 MULTU, 010 DIV, 011 DIVU,
//                        100 MTHI, 101 MTLO, 11x no-op
//   src1      in   [31:0] rs: dividend / multiplicand / MTHI-MTLO data
//   src2      in   [31:0] rt: divisor / multiplier
//   flush     in   cancel current or incoming operation
//   busy      out  operation in flight (not IDLE)
//   done      out  one-cycle pulse, HI/LO hold the new result
//   hi, lo    out  [31:0] HI/LO registers
// -----------------------------------------------------------------------------
module mdu_iter #(
   parameter int ITER_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [2:0]  mdu_op,
   input  logic [31:0] src1,
   input  logic [31:0] src2,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

   localparam logic [4:0] LAST_CNT = 5'(ITER_CYCLES - 1);

   function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
      return neg ? (~v + 64'd1) : v;
   endfunction

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   // Shared working register: multiply {upper partial, multiplier/low product},
   // divide {partial remainder, dividend/quotient}.
   logic [63:0] acc_q, acc_d;
   logic [31:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
   logic [31:0] s1raw_q, s1raw_d;   // raw dividend, returned on divide-by-zero
   logic        is_div_q, is_div_d;
   logic        neg_q, neg_d;       // product / quotient sign
   logic        rneg_q, rneg_d;     // remainder sign
   logic        dz_q, dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic        accept;
   logic        signed_op;
   logic        s1_neg, s2_neg;
   logic [31:0] mag1, mag2;
   logic [32:0] mul_sum;
   logic [63:0] mul_next;
   logic [32:0] div_shift;
   logic        div_ge;
   logic [31:0] div_diff;
   logic [63:0] div_next;
`ifdef MDU_FAST_MULT_EN
   logic [63:0] fast_prod;
`endif

   assign accept    = op_valid && (state_q == S_IDLE) && !flush;
   assign signed_op = ~mdu_op[0];
   assign s1_neg    = signed_op & src1[31];
   assign s2_neg    = signed_op & src2[31];
   assign mag1      = cond_neg32(src1, s1_neg);
   assign mag2      = cond_neg32(src2, s2_neg);

   // Shift-add step: add multiplicand into the upper half when the current
   // multiplier bit (LSB) is set, then shift the 65-bit result right.
   assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
   assign mul_next = {mul_sum, acc_q[31:1]};

   // Restoring divide step: bring the next dividend bit into the remainder
   // and subtract the divisor when it fits. The remainder stays below the
   // divisor, so a 32-bit difference is exact whenever div_ge holds.
   assign div_shift = {acc_q[63:32], acc_q[31]};
   assign div_ge    = div_shift >= {1'b0, opnd_q};
   assign div_diff  = div_shift[31:0] - opnd_q;
   assign div_next  = {(div_ge ? div_diff : div_shift[31:0]), acc_q[30:0], div_ge};

`ifdef MDU_FAST_MULT_EN
   assign fast_prod = {32'd0, mag1} * {32'd0, mag2};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         s1raw_q  <= '0;
         is_div_q <= 1'b0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         s1raw_q  <= s1raw_d;
         is_div_q <= is_div_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      s1raw_d  = s1raw_q;
      is_div_d = is_div_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               case (mdu_op)
                  3'b000, 3'b001, 3'b010, 3'b011: begin
                     is_div_d = mdu_op[1];
                     neg_d    = s1_neg ^ s2_neg;
                     rneg_d   = s1_neg;
                     dz_d     = (src2 == 32'd0);
                     s1raw_d  = src1;
                     cnt_d    = '0;
                     state_d  = S_ITER;
                     if (mdu_op[1]) begin
                        acc_d  = {32'd0, mag1};
                        opnd_d = mag2;
                     end else begin
`ifdef MDU_FAST_MULT_EN
                        acc_d   = fast_prod;
                        opnd_d  = mag1;
                        state_d = S_FIX;
`else
                        acc_d  = {32'd0, mag2};
                        opnd_d = mag1;
`endif
                     end
                  end
                  3'b100:  hi_d = src1;
                  3'b101:  lo_d = src1;
                  default: ;
               endcase
            end
         end

         S_ITER: begin
            if (flush) begin
               state_d = S_IDLE;
            end else begin
               acc_d = is_div_q ? div_next : mul_next;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == LAST_CNT) begin
                  state_d = S_FIX;
               end
            end
         end

         S_FIX: begin
            state_d = S_IDLE;
            if (!flush) begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  {hi_d, lo_d} = cond_neg64(acc_q, neg_q);
               end else if (dz_q) begin
                  hi_d = s1raw_q;
                  lo_d = 32'hFFFF_FFFF;
               end else begin
                  lo_d = cond_neg32(acc_q[31:0], neg_q);
                  hi_d = cond_neg32(acc_q[63:32], rneg_q);
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign op_ready = (state_q == S_IDLE);
   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit beside the execute-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests from execute through a valid/ready handshake and runs multi-cycle operations.
- Owns the architectural HI/LO registers.
- Pipeline stalls on busy; an exception flush cancels in-flight work.

Parameters:
- ITER_CYCLES, 32, number of iteration cycles for iterative mult/div; fixed at 32 for 32-bit operands.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- op_valid  input  1  request present
- op_ready  output  1  unit can accept (state==IDLE)
- mdu_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
- src1  input  32  rs operand (dividend / multiplicand / MTHI/MTLO data)
- src2  input  32  rt operand (divisor / multiplier)
- flush  input  1  cancel current/incoming operation
- busy  output  1  operation in flight (state!=IDLE)
- done  output  1  one-cycle pulse, HI/LO hold new result
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, done=0, busy=0, op_ready=1. Reset mid-operation discards all work.
- Accept edge E0 = op_valid & op_ready & ~flush. Operands and op are latched at E0.
- States:
  - IDLE: op_ready=1.
  - ITER: counter 0..31.
  - FIX: sign correction and HI/LO write.
  - IDLE again.
- Transitions:
  - IDLE→ITER on accepted MULT/MULTU/DIV/DIVU.
  - ITER→FIX when counter==31, i.e. after 32 ITER edges E1..E32.
  - FIX→IDLE at E33. HI/LO are written at E33; done=1 during the cycle after E33 only.
  - Total: result visible 33 cycles after accept. op_ready returns to 1 in the same cycle done is 1.
- MTHI/MTLO: written at E0 directly into hi/lo. State stays IDLE, no done pulse. Back-to-back MTHI/MTLO accepted every cycle.
- No-op codes (11x): accepted, no state change, no done.
- Signed ops (MULT, DIV):
  - Operands converted to magnitudes at E0.
  - Signs recorded: product/quotient sign = s1^s2; remainder sign = s1.
  - Conditional negation applied in FIX.
- Multiply: shift-add, 32×32→64 unsigned magnitude. {hi,lo} = 64-bit product after sign fix.
- Divide: restoring radix-2, one quotient bit per ITER cycle. lo=quotient, hi=remainder.
- Divide by zero: completes with normal latency; hi=src1 (unmodified), lo=32'hFFFF_FFFF, for both DIV and DIVU.
- 0x8000_0000 DIV 0xFFFF_FFFF: lo=0x8000_0000, hi=0. No exception raised.
- Flush: synchronous, highest priority after reset.
  - In any state → IDLE next edge; hi/lo unchanged; no done.
  - flush with op_valid in the same cycle: request not accepted.
  - flush in the FIX cycle: HI/LO write suppressed.
- op_valid while busy is ignored: op_ready=0 and no latching. The requester must hold the request.

Optional Feature:
- MDU_FAST_MULT_EN
- Defined:
  - MULT/MULTU skip ITER and go IDLE→FIX using a single-cycle 32×32 array product (synthesis multiplier).
  - HI/LO written at E1; done high the cycle after E1.
  - Divide is unchanged at 33 cycles.
- Undefined: multiply uses the 32-cycle shift-add path with 33-cycle latency identical to divide.

Test Plan:
- MULTU src1=0xFFFF_FFFF, src2=0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001; done 33 cycles after accept (1 cycle with MDU_FAST_MULT_EN); busy=1 throughout.
- MULT src1=0xFFFF_FFFE (−2), src2=3 → hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
- DIV cases:
  - src1=0xFFFF_FFF9 (−7), src2=2 → lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1).
  - DIVU src1=100, src2=7 → lo=14, hi=2.
  - DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- Divide by zero: DIVU src1=0x1234_5678, src2=0 → hi=0x1234_5678, lo=0xFFFF_FFFF after 33 cycles.
- MTHI 0xAAAA_5555 then MTLO 0x5555_AAAA on consecutive cycles → hi/lo updated at each accept edge, no done, op_ready held 1. Then DIV with flush at iteration 10 → hi/lo remain 0xAAAA_5555/0x5555_AAAA, no done, op_ready=1 next cycle.
- Reset and handshake:
  - Assert reset mid-DIV → hi=lo=0, busy=0 immediately.
  - op_valid held during busy → accepted only in the cycle done=1.
